// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo_ctrl FIFO controller.
//   - Default entry/address widths.
//   - fifo_depth(): number of entries for a given address width.
//   - ram_port_t: one dual-port RAM port bundle (address, chip enable,
//     write/read select, data), sized for the default configuration.
package fifo_pkg;

  localparam int unsigned FifoDataWidth = 8;
  localparam int unsigned FifoAddrWidth = 8;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // write_read: 1 = write, 0 = read.
  typedef struct packed {
    logic [FifoAddrWidth-1:0] address;
    logic                     chip_enable;
    logic                     write_read;
    logic [FifoDataWidth-1:0] data;
  } ram_port_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: ADDR_WIDTH+1 bit wrap-bit pointer for the FIFO controller.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (pointer -> 0)
//   inc_i      advance the pointer by one entry
//   clr_i      synchronous clear, has priority over inc_i
//   addr_o     registered RAM address (low ADDR_WIDTH bits)
//   ptr_nxt_o  next-state pointer including the wrap bit
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FifoAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  input  logic                  clr_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH:0]   ptr_nxt_o
);

  logic [ADDR_WIDTH:0] ptr_q, ptr_d;

  // Low bits wrap naturally from DEPTH-1 to 0; the carry toggles the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign addr_o    = ptr_q[ADDR_WIDTH-1:0];
  assign ptr_nxt_o = ptr_d;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller driving a dual-port RAM
// (port 0 writes, port 1 reads, registered read data with one cycle latency).
//   clk, rst_n              clock, asynchronous active-low reset
//   push, wr_data           write request and data
//   pop                     read request
//   flush                   synchronous clear of pointers and status
//   rd_data, rd_valid       read data and its one-cycle valid strobe
//   full, empty             count == DEPTH / count == 0
//   almost_full/_empty      count >= AF_LEVEL / count <= AE_LEVEL
//   count                   occupancy, ADDR_WIDTH+1 bits
//   ram_*_0                 RAM write port (address, chip enable, write/read, data)
//   ram_*_1, ram_data_1     RAM read port and its registered read data
//   ram_full                copy of full for the RAM
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FifoDataWidth,
  parameter int unsigned ADDR_WIDTH = FifoAddrWidth,
  parameter int unsigned AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] ram_address_0,
  output logic                  ram_chip_enable_0,
  output logic                  ram_write_read_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0] ram_address_1,
  output logic                  ram_chip_enable_1,
  output logic                  ram_write_read_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1,
  output logic                  ram_full
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned CntWidth = ADDR_WIDTH + 1;
  localparam logic [CntWidth-1:0] AfLevel = CntWidth'(AF_LEVEL);
  localparam logic [CntWidth-1:0] AeLevel = CntWidth'(AE_LEVEL);

  // Same layout as fifo_pkg::ram_port_t, sized to this instance.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic                  chip_enable;
    logic                  write_read;
    logic [DATA_WIDTH-1:0] data;
  } ram_bus_t;

  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  rd_valid_q;

  logic                  push_acc, pop_acc;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [ADDR_WIDTH:0]   wr_nxt, rd_nxt;
  ram_bus_t              wr_bus, rd_bus;

  // Acceptance uses registered flags only. Pop is blocked while empty, so a
  // same-cycle push never aliases the read address; flush blocks both.
  assign push_acc = push & ~full_q & ~flush;
  assign pop_acc  = pop & ~empty_q & ~flush;

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (push_acc),
    .clr_i     (flush),
    .addr_o    (wr_addr),
    .ptr_nxt_o (wr_nxt)
  );

  fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (pop_acc),
    .clr_i     (flush),
    .addr_o    (rd_addr),
    .ptr_nxt_o (rd_nxt)
  );

  // Status is derived from the next-state pointers so every flag is registered
  // and in step with the pointers. The modular difference of wrap-bit pointers
  // is the occupancy, 0..DEPTH.
  always_comb begin
    count_d = wr_nxt - rd_nxt;
    full_d  = (wr_nxt[ADDR_WIDTH] != rd_nxt[ADDR_WIDTH]) &&
              (wr_nxt[ADDR_WIDTH-1:0] == rd_nxt[ADDR_WIDTH-1:0]);
    empty_d = (wr_nxt == rd_nxt);
    af_d    = (count_d >= AfLevel);
    ae_d    = (count_d <= AeLevel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      rd_valid_q <= pop_acc;
    end
  end

  always_comb begin
    wr_bus.address     = wr_addr;
    wr_bus.chip_enable = push_acc;
    wr_bus.write_read  = 1'b1;
    wr_bus.data        = wr_data;

    rd_bus.address     = rd_addr;
    rd_bus.chip_enable = pop_acc;
    rd_bus.write_read  = 1'b0;
    rd_bus.data        = ram_data_1;
  end

  assign ram_address_0     = wr_bus.address;
  assign ram_chip_enable_0 = wr_bus.chip_enable;
  assign ram_write_read_0  = wr_bus.write_read;
  assign ram_data_0        = wr_bus.data;

  assign ram_address_1     = rd_bus.address;
  assign ram_chip_enable_1 = rd_bus.chip_enable;
  assign ram_write_read_1  = rd_bus.write_read;

  // The RAM registers its read data, so it lines up with rd_valid_q.
  assign rd_data      = rd_bus.data;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign ram_full     = full_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky until flush or reset; flush wins over a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push && full_q) begin
        overflow_q <= 1'b1;
      end
      if (pop && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with ADDR_WIDTH=2 (DEPTH=4), a simple
// registered-read RAM model, a queue-based reference model and directed stimulus.
module tb_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned AE    = 2;

  logic          clk;
  logic          rst_n;
  logic          push, pop, flush;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic [AW-1:0] ram_address_0, ram_address_1;
  logic          ram_chip_enable_0, ram_chip_enable_1;
  logic          ram_write_read_0, ram_write_read_1;
  logic [DW-1:0] ram_data_0, ram_data_1;
  logic          ram_full;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .push              (push),
    .wr_data           (wr_data),
    .pop               (pop),
    .flush             (flush),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .full              (full),
    .empty             (empty),
    .almost_full       (almost_full),
    .almost_empty      (almost_empty),
    .count             (count),
    .ram_address_0     (ram_address_0),
    .ram_chip_enable_0 (ram_chip_enable_0),
    .ram_write_read_0  (ram_write_read_0),
    .ram_data_0        (ram_data_0),
    .ram_address_1     (ram_address_1),
    .ram_chip_enable_1 (ram_chip_enable_1),
    .ram_write_read_1  (ram_write_read_1),
    .ram_data_1        (ram_data_1),
    .ram_full          (ram_full)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow          (overflow),
    .underflow         (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM: write port 0, registered read port 1, read data 0 in reset.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_data_1 <= '0;
    end else begin
      if (ram_chip_enable_0 && ram_write_read_0) mem[ram_address_0] <= ram_data_0;
      if (ram_chip_enable_1 && !ram_write_read_1) ram_data_1 <= mem[ram_address_1];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, pointers as entry counters.
  logic [DW-1:0] q[$];
  int            wr_total, rd_total;
  logic          rv_m;
  logic [DW-1:0] rd_m;
  logic          ovf_m, unf_m;

  task automatic model_reset();
    q.delete();
    wr_total = 0;
    rd_total = 0;
    rv_m     = 1'b0;
    rd_m     = '0;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic [DW-1:0] d, input logic o,
                            input logic f);
    int  n;
    logic pa, pp;
    n = q.size();
    if (f) begin
      q.delete();
      wr_total = 0;
      rd_total = 0;
      rv_m     = 1'b0;
      ovf_m    = 1'b0;
      unf_m    = 1'b0;
    end else begin
      pa = p && (n < DEPTH);
      pp = o && (n > 0);
      if (p && n == DEPTH) ovf_m = 1'b1;
      if (o && n == 0) unf_m = 1'b1;
      rv_m = pp;
      if (pp) begin
        rd_m = q.pop_front();
        rd_total++;
      end
      if (pa) begin
        q.push_back(d);
        wr_total++;
      end
    end
  endtask

  // Inputs change 1 time unit after the edge; the model steps on the edge.
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic o, input logic f);
    #1;
    push    = p;
    wr_data = d;
    pop     = o;
    flush   = f;
    @(posedge clk);
    if (rst_n) model_step(p, d, o, f);
  endtask

  // Continuous comparison on every falling edge.
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("ram_full", 32'(ram_full), 32'(n == DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(rv_m));
    if (rv_m) chk("rd_data", 32'(rd_data), 32'(rd_m));
    if (!rst_n) chk("rd_data_rst", 32'(rd_data), 32'd0);
    chk("ce0", 32'(ram_chip_enable_0), 32'(push && !flush && n < DEPTH));
    chk("ce1", 32'(ram_chip_enable_1), 32'(pop && !flush && n > 0));
    chk("addr0", 32'(ram_address_0), 32'(wr_total % DEPTH));
    chk("addr1", 32'(ram_address_1), 32'(rd_total % DEPTH));
    chk("wdata0", 32'(ram_data_0), 32'(wr_data));
    chk("wr0", 32'(ram_write_read_0), 32'd1);
    chk("wr1", 32'(ram_write_read_1), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("underflow", 32'(underflow), 32'(unf_m));
`endif
  end

  logic [DW-1:0] exp4 [4];

  initial begin
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_reset();
    rst_n   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    wr_data = '0;
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;

    // Fill to full, then a rejected fifth push.
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    #2;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_af", 32'(almost_full), 32'd1);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    #2;
    chk("fifth_ce0", 32'(ram_chip_enable_0), 32'd0);
    chk("fifth_count", 32'(count), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      #2;
      chk("pop_valid", 32'(rd_valid), 32'd1);
      chk("pop_data", 32'(rd_data), 32'(exp4[i]));
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Push+pop while empty: only the push is taken.
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    #2;
    chk("pe_count", 32'(count), 32'd1);
    chk("pe_valid", 32'(rd_valid), 32'd0);
    cyc(1'b1, 8'hBB, 1'b0, 1'b0);
    cyc(1'b1, 8'hCC, 1'b1, 1'b0);
    #2;
    chk("mid_count", 32'(count), 32'd2);
    chk("mid_data", 32'(rd_data), 32'hAA);

    // Push+pop while full: only the pop is taken.
    cyc(1'b1, 8'hDD, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    #2;
    chk("pf_count", 32'(count), 32'd3);
    chk("pf_data", 32'(rd_data), 32'hBB);

    // Ten simultaneous push/pop cycles wrap both pointers.
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
    #2;
    chk("wrap_count", 32'(count), 32'd3);
    chk("wrap_data", 32'(rd_data), 32'h66);

    // Flush beats a same-cycle push; a later pop is rejected.
    cyc(1'b1, 8'h77, 1'b0, 1'b1);
    #2;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_valid", 32'(rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    chk("post_flush_valid", 32'(rd_valid), 32'd0);
    chk("post_flush_count", 32'(count), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_set", 32'(underflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    chk("unf_hold", 32'(underflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    #2;
    chk("unf_clr", 32'(underflow), 32'd0);
`endif

    // Asynchronous reset in the middle of a burst.
    cyc(1'b1, 8'h31, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_ae", 32'(almost_empty), 32'd1);
    chk("arst_af", 32'(almost_full), 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    #2;
    push  = 1'b0;
    pop   = 1'b0;
    rst_n = 1'b1;

    // Short burst after reset, checked by the model.
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    cyc(1'b1, 8'h42, 1'b1, 1'b0);
    cyc(1'b1, 8'h43, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    chk("final_data", 32'(rd_data), 32'h43);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
